spi_cfg_sequencer: RTL and testbench



---
 rtl/spi_cfg_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_spi_cfg_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_sequencer.sv
// SPI master: shifts a config table to the slave, reads back one word, compares.
// Ports: sys_clk/sys_rst_n, cfg_*/exp_* table load, start, spi_* pins, busy/done/pass.
module spi_cfg_sequencer #(
  parameter int CLK_DIV      = 100,
  parameter int WORD_W       = 16,
  parameter int NUM_WORDS    = 16,
  parameter int LEAD_PERIODS = 4,
  parameter int GAP_PERIODS  = 10
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_WORDS)-1:0] cfg_addr,
  input  logic [WORD_W-1:0]            cfg_wdata,
  input  logic                         exp_we,
  input  logic [WORD_W-1:0]            exp_wdata,
  input  logic                         start,
  input  logic                         spi_out,
  output logic                         spi_in,
  output logic                         spi_clk_out,
  output logic                         spi_en,
  output logic                         busy,
  output logic                         done,
  output logic                         pass
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam int BW = $clog2(WORD_W);
  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = $clog2(LEAD_PERIODS + GAP_PERIODS + WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_WRITE, S_GAP, S_READ, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic              sclk_q, sclk_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     word_q, word_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [WORD_W-1:0] cap_q, cap_d;
  logic              spi_in_q, spi_in_d;
  logic              spi_en_q, spi_en_d;
  logic              spi_clk_q, spi_clk_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [WORD_W-1:0] tbl_q [NUM_WORDS];
  logic [WORD_W-1:0] exp_q;

  logic          tick, rise, fall;
  logic [AW-1:0] nxt_word;
  logic [BW-1:0] nxt_bit;

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    bit_d    = bit_q;
    cap_d    = cap_q;
    spi_in_d = spi_in_q;
    spi_en_d = spi_en_q;
    done_d   = done_q;
    pass_d   = pass_q;

    tick   = busy && (div_q == DW'(CLK_DIV - 1));
    rise   = tick && !sclk_q;
    fall   = tick && sclk_q;
    div_d  = (busy && !tick) ? div_q + 1'b1 : '0;
    sclk_d = busy ? (sclk_q ^ tick) : 1'b0;

    if (bit_q == '0) begin
      nxt_bit  = BW'(WORD_W - 1);
      nxt_word = word_q + 1'b1;
    end else begin
      nxt_bit  = bit_q - 1'b1;
      nxt_word = word_q;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_LEAD;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          div_d    = '0;
          sclk_d   = 1'b0;
          cnt_d    = '0;
          word_d   = '0;
          bit_d    = '0;
          spi_en_d = 1'b1;
          spi_in_d = 1'b0;
        end
      end
      S_LEAD: begin
        if (fall) begin
          if (cnt_q == CW'(LEAD_PERIODS - 1)) begin
            state_d  = S_WRITE;
            word_d   = '0;
            bit_d    = BW'(WORD_W - 1);
            spi_in_d = tbl_q[0][WORD_W-1];
            spi_en_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (fall) begin
          // Reaching a fall on the last bit means its rise already happened.
          if (word_q == AW'(NUM_WORDS - 1) && bit_q == '0) begin
            state_d  = S_GAP;
            spi_en_d = 1'b1;
            spi_in_d = 1'b0;
            cnt_d    = '0;
          end else begin
            word_d   = nxt_word;
            bit_d    = nxt_bit;
            spi_in_d = tbl_q[nxt_word][nxt_bit];
          end
        end
      end
      S_GAP: begin
        if (fall) begin
          if (cnt_q == CW'(GAP_PERIODS - 1)) begin
            state_d  = S_READ;
            spi_en_d = 1'b0;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_READ: begin
        if (rise) begin
          cap_d = {cap_q[WORD_W-2:0], spi_out};
          cnt_d = cnt_q + 1'b1;
        end
        if (fall && cnt_q == CW'(WORD_W)) begin
          state_d  = S_DONE;
          spi_en_d = 1'b1;
          done_d   = 1'b1;
          pass_d   = (cap_q == exp_q);
        end
      end
      default: state_d = S_IDLE;
    endcase

    spi_clk_d = sclk_d & ~spi_en_d;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      sclk_q    <= 1'b0;
      cnt_q     <= '0;
      word_q    <= '0;
      bit_q     <= '0;
      cap_q     <= '0;
      spi_in_q  <= 1'b0;
      spi_en_q  <= 1'b1;
      spi_clk_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      bit_q     <= bit_d;
      cap_q     <= cap_d;
      spi_in_q  <= spi_in_d;
      spi_en_q  <= spi_en_d;
      spi_clk_q <= spi_clk_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  // Table and expected word survive reset; loads are locked out mid-run.
  always_ff @(posedge sys_clk) begin
    if (cfg_we && !busy) tbl_q[cfg_addr] <= cfg_wdata;
    if (exp_we && !busy) exp_q <= exp_wdata;
  end

  assign spi_in      = spi_in_q;
  assign spi_en      = spi_en_q;
  assign spi_clk_out = spi_clk_q;
  assign done        = done_q;
  assign pass        = pass_q;
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Bench for spi_cfg_sequencer: slave model, frame capture, vector table.
module tb_spi_cfg_sequencer;
  localparam int N = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        exp_we = 1'b0;
  logic [15:0] exp_wdata = '0;
  logic        start = 1'b0;
  logic        spi_out;
  logic        spi_in, spi_clk_out, spi_en, busy, done, pass;

  always #5 sys_clk = ~sys_clk;

  spi_cfg_sequencer #(.CLK_DIV(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .exp_we(exp_we), .exp_wdata(exp_wdata), .start(start),
    .spi_out(spi_out), .spi_in(spi_in), .spi_clk_out(spi_clk_out),
    .spi_en(spi_en), .busy(busy), .done(done), .pass(pass)
  );

  // Slave/monitor: phase 0 lead, 1 write, 2 gap, 3 read, 4 done.
  logic        clr = 1'b0;
  int          phase, rrise, rfall, hi0, hi2, busy_cnt, in_bad, clk_bad;
  logic        prev_clk, prev_en;
  logic        wbits[$];
  logic [15:0] resp = '0;
  logic [15:0] rsh;

  assign rsh     = resp << rfall;
  assign spi_out = (phase == 3) ? rsh[15] : 1'b0;

  always @(negedge sys_clk) begin
    if (clr) begin
      phase = 0; rrise = 0; rfall = 0; hi0 = 0; hi2 = 0;
      busy_cnt = 0; in_bad = 0; clk_bad = 0;
      prev_clk = 1'b0; prev_en = 1'b1;
      wbits.delete();
    end else begin
      if (spi_en !== prev_en) phase++;
      if (spi_clk_out && !prev_clk) begin
        if (spi_en) clk_bad++;
        else if (phase == 1) wbits.push_back(spi_in);
        else if (phase == 3) rrise++;
      end
      if (!spi_clk_out && prev_clk && phase == 3) rfall++;
      if (busy) busy_cnt++;
      if (busy && spi_en) begin
        if (phase == 0) hi0++;
        if (phase == 2) hi2++;
        if (spi_in) in_bad++;
        if (spi_clk_out) clk_bad++;
      end
      prev_clk = spi_clk_out;
      prev_en  = spi_en;
    end
  end

  int          total = 0;
  int          bad = 0;
  logic [15:0] model[N];

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic wr_cfg(input logic [3:0] a, input logic [15:0] d);
    @(posedge sys_clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(posedge sys_clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic wr_exp(input logic [15:0] d);
    @(posedge sys_clk); #1;
    exp_we = 1'b1; exp_wdata = d;
    @(posedge sys_clk); #1;
    exp_we = 1'b0;
  endtask

  task automatic start_run(input logic we, input logic [3:0] a,
                           input logic [15:0] d);
    @(posedge sys_clk); #1;
    clr = 1'b1;
    @(posedge sys_clk); #1;
    clr = 1'b0;
    start = 1'b1; cfg_we = we; cfg_addr = a; cfg_wdata = d;
    @(posedge sys_clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_pass_clr", pass, 0);
  endtask

  task automatic finish_run(input logic exp_pass, input string tag);
    int errs;
    logic [15:0] w;
    for (int i = 0; i < 5000 && !done; i++) @(negedge sys_clk);
    if (!done) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_pass"}, pass, exp_pass);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_en"}, spi_en, 1);
    chk({tag, "_sclk"}, spi_clk_out, 0);
    chk({tag, "_nbits"}, wbits.size(), 256);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      w = model[i / 16];
      if (i >= wbits.size() || wbits[i] !== w[15 - (i % 16)]) errs++;
    end
    chk({tag, "_frame_errs"}, errs, 0);
    chk({tag, "_lead_cyc"}, hi0, 16);
    chk({tag, "_gap_cyc"}, hi2, 40);
    chk({tag, "_rd_rises"}, rrise, 16);
    chk({tag, "_clk_when_en_hi"}, clk_bad, 0);
    chk({tag, "_din_when_en_hi"}, in_bad, 0);
    total++;
    if (busy_cnt < 1142 || busy_cnt > 1148) begin
      bad++;
      $display("FAIL %s_run_len got=%0d want=1142..1148", tag, busy_cnt);
    end
  endtask

  typedef struct {
    logic [15:0] resp;
    logic [15:0] expv;
    logic        pass;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] tbl[N];
    logic [15:0] w;
    tbl = '{16'hFFFF, 16'hFFFF, 16'h0003, 16'hFFFF,
            16'h4431, 16'h1123, 16'h0000, 16'h5554,
            16'hFFFF, 16'h0000, 16'h0007, 16'h0000,
            16'h0000, 16'h0000, 16'h0004, 16'h0000};
    vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b1};
    vecs[1] = '{16'h5554, 16'hFFFF, 1'b0};
    vecs[2] = '{16'h5554, 16'h5554, 1'b1};
    vecs[3] = '{16'h8001, 16'h8000, 1'b0};

    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_spi_in", spi_in, 0);
    chk("rst_sclk", spi_clk_out, 0);
    chk("rst_en", spi_en, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < N; i++) begin
      model[i] = tbl[i];
      wr_cfg(4'(i), tbl[i]);
    end

    foreach (vecs[i]) begin
      wr_exp(vecs[i].expv);
      resp = vecs[i].resp;
      start_run(1'b0, '0, '0);
      finish_run(vecs[i].pass, $sformatf("vec%0d", i));
    end

    // start and table write mid-frame are both dropped
    wr_exp(16'hFFFF);
    resp = 16'hFFFF;
    start_run(1'b0, '0, '0);
    for (int i = 0; i < 5000 && wbits.size() < 83; i++)
      @(negedge sys_clk);
    chk("midrun_reach_w5", wbits.size() >= 83, 1);
    @(posedge sys_clk); #1;
    start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 16'h1234;
    @(posedge sys_clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    finish_run(1'b1, "midrun");
    start_run(1'b0, '0, '0);
    finish_run(1'b1, "rerun");

    // reset while in the gap
    start_run(1'b0, '0, '0);
    for (int i = 0; i < 5000 && phase != 2; i++) @(negedge sys_clk);
    chk("gap_reached", phase, 2);
    repeat (5) @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    chk("mrst_en", spi_en, 1);
    chk("mrst_sclk", spi_clk_out, 0);
    chk("mrst_spi_in", spi_in, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    start_run(1'b0, '0, '0);
    finish_run(1'b1, "after_rst");

    // table write lands on the same cycle as start
    wr_exp(16'h5554);
    resp = 16'h5554;
    start_run(1'b1, 4'd15, 16'h8001);
    model[15] = 16'h8001;
    finish_run(1'b1, "a15");
    w = '0;
    for (int i = 0; i < 16; i++)
      if (240 + i < wbits.size()) w[15 - i] = wbits[240 + i];
    chk("a15_last16", w, 16'h8001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
